decryption_session_ctrl: RTL

- Single-clock session scheduler in front of the decryption subsystem. NUM_REQ requesters compete for it, and arbitration is round-robin.
- For each winner the block programs the cipher select register and the matching key register over the register access bus. It then grants the datapath to that requester until the requester releases it.
- Before the next session starts, it waits for the ciphers to drain.

---
 rtl/decryption_session_ctrl_pkg.sv | 28 ++
 rtl/decryption_session_ctrl_rr_arbiter.sv | 25 ++
 rtl/decryption_session_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/decryption_session_ctrl_pkg.sv
// decryption_ctrl_pkg: session states, cipher ids and default register map (readback states only with DECRYPTION_READBACK_VERIFY_EN)
package decryption_ctrl_pkg;
   typedef enum logic [3:0] {
      IDLE,
      ARB,
      WR_SEL,
      WAIT_SEL,
`ifdef DECRYPTION_READBACK_VERIFY_EN
      RD_SEL,
      WAIT_RD_SEL,
      RD_KEY,
      WAIT_RD_KEY,
`endif
      WR_KEY,
      WAIT_KEY,
      GRANT,
      DRAIN,
      ERR
   } state_e;
   localparam logic [1:0] CAESAR = 2'd0;
   localparam logic [1:0] SCYTALE = 2'd1;
   localparam logic [1:0] ZIGZAG = 2'd2;
   localparam logic [1:0] INVALID = 2'd3;
   localparam logic [7:0] DEF_ADDR_SELECT = 8'h00;
   localparam logic [7:0] DEF_ADDR_CAESAR = 8'h10;
   localparam logic [7:0] DEF_ADDR_SCYTALE = 8'h12;
   localparam logic [7:0] DEF_ADDR_ZIGZAG = 8'h14;
endpackage

// File: rtl/decryption_session_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner search starting after ptr, with wrap-around
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PW = $clog2(NUM_REQ)
) (
   input logic [NUM_REQ-1:0] req,
   input logic [PW-1:0] ptr,
   output logic [PW-1:0] win,
   output logic vld
);
   logic [PW-1:0] j;
   // walk the search order backwards so the nearest requester after ptr is written last
   always_comb begin
      win = '0;
      vld = 1'b0;
      j = '0;
      for (int i = NUM_REQ; i > 0; i--) begin
         j = PW'((int'(ptr) + i) % NUM_REQ);
         if (req[j]) begin
            win = j;
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/decryption_session_ctrl.sv
// decryption_session_ctrl: round-robin session scheduler programming cipher select/key registers; DECRYPTION_READBACK_VERIFY_EN adds register readback checks
module decryption_session_ctrl import decryption_ctrl_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int REG_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] ADDR_SELECT = ADDR_WIDTH'(DEF_ADDR_SELECT),
   parameter logic [ADDR_WIDTH-1:0] ADDR_CAESAR = ADDR_WIDTH'(DEF_ADDR_CAESAR),
   parameter logic [ADDR_WIDTH-1:0] ADDR_SCYTALE = ADDR_WIDTH'(DEF_ADDR_SCYTALE),
   parameter logic [ADDR_WIDTH-1:0] ADDR_ZIGZAG = ADDR_WIDTH'(DEF_ADDR_ZIGZAG),
   parameter int TIMEOUT = 16,
   parameter int DRAIN_CYCLES = 4
) (
   input logic clk_sys,
   input logic rst,
   input logic [NUM_REQ-1:0] req_i,
   input logic [2*NUM_REQ-1:0] req_sel_i,
   input logic [REG_WIDTH*NUM_REQ-1:0] req_key_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [NUM_REQ-1:0] err_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic write_o,
   output logic read_o,
   output logic [REG_WIDTH-1:0] wdata_o,
   input logic [REG_WIDTH-1:0] rdata_i,
   input logic done_i,
   input logic error_i,
   input logic dec_busy_i,
   output logic active_o
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2((TIMEOUT > DRAIN_CYCLES ? TIMEOUT : DRAIN_CYCLES) + 1);
   state_e state, state_n;
   logic [PW-1:0] rr_ptr, win_r, arb_win;
   logic arb_vld;
   logic [1:0] sel_r, arb_sel;
   logic [REG_WIDTH-1:0] key_r;
   logic [CW-1:0] cnt;
   logic sel_ph, key_ph, ok, tmo, fail;
   logic [ADDR_WIDTH-1:0] key_addr;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req(req_i),
      .ptr(rr_ptr),
      .win(arb_win),
      .vld(arb_vld)
   );
   assign arb_sel = req_sel_i[arb_win*2 +: 2];
`ifdef DECRYPTION_READBACK_VERIFY_EN
   logic rd_ok, rd_fail;
   assign sel_ph = state inside {WR_SEL, WAIT_SEL, RD_SEL, WAIT_RD_SEL};
   assign key_ph = state inside {WR_KEY, WAIT_KEY, RD_KEY, WAIT_RD_KEY};
   assign read_o = state inside {RD_SEL, RD_KEY};
   assign rd_ok = ok && rdata_i == wdata_o;
   assign rd_fail = (done_i && !rd_ok) || tmo;
`else
   logic unused_rdata;
   assign sel_ph = state inside {WR_SEL, WAIT_SEL};
   assign key_ph = state inside {WR_KEY, WAIT_KEY};
   assign read_o = 1'b0;
   assign unused_rdata = ^rdata_i;
`endif
   assign key_addr = sel_r == SCYTALE ? ADDR_SCYTALE : sel_r == ZIGZAG ? ADDR_ZIGZAG : ADDR_CAESAR;
   assign addr_o = sel_ph ? ADDR_SELECT : key_ph ? key_addr : '0;
   assign wdata_o = sel_ph ? REG_WIDTH'(sel_r) : key_ph ? key_r : '0;
   assign write_o = state inside {WR_SEL, WR_KEY};
   assign gnt_o = state == GRANT ? NUM_REQ'(1) << win_r : '0;
   assign err_o = state == ERR ? NUM_REQ'(1) << win_r : '0;
   assign active_o = state != IDLE;
   // a done_i in the final timeout cycle still counts as success
   assign ok = done_i && !error_i;
   assign tmo = !done_i && cnt == CW'(TIMEOUT - 1);
   assign fail = (done_i && error_i) || tmo;
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = |req_i ? ARB : IDLE;
         ARB: state_n = !arb_vld ? IDLE : arb_sel == INVALID ? ERR : WR_SEL;
         WR_SEL: state_n = WAIT_SEL;
         WR_KEY: state_n = WAIT_KEY;
`ifdef DECRYPTION_READBACK_VERIFY_EN
         WAIT_SEL: state_n = ok ? RD_SEL : fail ? ERR : WAIT_SEL;
         RD_SEL: state_n = WAIT_RD_SEL;
         WAIT_RD_SEL: state_n = rd_ok ? WR_KEY : rd_fail ? ERR : WAIT_RD_SEL;
         WAIT_KEY: state_n = ok ? RD_KEY : fail ? ERR : WAIT_KEY;
         RD_KEY: state_n = WAIT_RD_KEY;
         WAIT_RD_KEY: state_n = rd_ok ? GRANT : rd_fail ? ERR : WAIT_RD_KEY;
`else
         WAIT_SEL: state_n = ok ? WR_KEY : fail ? ERR : WAIT_SEL;
         WAIT_KEY: state_n = ok ? GRANT : fail ? ERR : WAIT_KEY;
`endif
         GRANT: state_n = req_i[win_r] ? GRANT : DRAIN;
         DRAIN: state_n = !dec_busy_i && cnt == CW'(DRAIN_CYCLES - 1) ? IDLE : DRAIN;
         ERR: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // one counter serves both the bus timeout and the drain streak; it restarts on every state change
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= PW'(NUM_REQ - 1);
         win_r <= '0;
         sel_r <= '0;
         key_r <= '0;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= (state_n != state || (state == DRAIN && dec_busy_i)) ? '0 : cnt + 1'b1;
         if (state == ARB) begin
            win_r <= arb_win;
            sel_r <= arb_sel;
            key_r <= req_key_i[arb_win*REG_WIDTH +: REG_WIDTH];
         end
         if (state == ERR || (state == DRAIN && state_n == IDLE))
            rr_ptr <= win_r;
      end
   end
endmodule
